wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width of all write-data paths.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port pipe_wen, input, 1: single-cycle pipeline writeback request.
REQ-005 SHALL have port pipe_rd, input, 5: pipeline destination register.
REQ-006 SHALL have port pipe_data, input, XLEN: pipeline write data.
REQ-007 SHALL have port md_valid, input, 1: multi-cycle unit (mul/div) result valid.
REQ-008 SHALL have port md_ready, output, 1: result accepted when md_valid & md_ready.
REQ-009 SHALL have port md_rd, input, 5: multi-cycle result destination.
REQ-010 SHALL have port md_data, input, XLEN: multi-cycle result data.
REQ-011 SHALL have port md_issue, input, 1: multi-cycle op issued this cycle.
REQ-012 SHALL have port md_issue_rd, input, 5: destination of the issued op.
REQ-013 SHALL have ports rs1 and rs2, input, 5 each: hazard query addresses.
REQ-014 SHALL have ports rs1_busy and rs2_busy, output, 1 each: query register has a pending multi-cycle write.
REQ-015 SHALL have port stall_req, output, 1: pipeline must hold writeback.
REQ-016 SHALL have port sb_err, output, 1: sticky scoreboard error.
REQ-017 SHALL have port W_en, output, 1: register-file write enable (registered).
REQ-018 SHALL have port Rd, output, 5: register-file write address (registered).
REQ-019 SHALL have port Wr_data, output, XLEN: register-file write data (registered).

Function
REQ-020 SHALL hold multi-cycle results in a 2-entry FIFO (data+rd); md_ready = (count<2) & ~rst.
REQ-021 SHALL push on md_valid & md_ready; md_rd==0 results SHALL be accepted and discarded (no push).
REQ-022 SHALL NOT push when full, even if a pop occurs that cycle.
REQ-023 Arbitration each cycle: if pipe_wen & pipe_rd!=0, next W_en=1, Rd=pipe_rd, Wr_data=pipe_data; else if FIFO non-empty, pop head, next W_en=1 with head rd/data; else next W_en=0, Rd/Wr_data hold.
REQ-024 Pipeline has strict priority; pipe_wen with pipe_rd==0 SHALL count as no request.
REQ-025 Latency: request in cycle N appears on W_en/Rd/Wr_data in cycle N+1.
REQ-026 Push and pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-027 stall_req SHALL equal (count==2), combinational from state.
REQ-028 Scoreboard: 32 busy bits; md_issue & md_issue_rd!=0 sets busy[md_issue_rd].
REQ-029 busy[r] SHALL clear in the cycle a FIFO pop for r is selected; a discarded rd==0 result clears nothing.
REQ-030 Simultaneous set and clear of the same register SHALL leave it set.
REQ-031 md_issue to an already-busy register (not cleared that cycle) SHALL set sb_err, which holds until reset.
REQ-032 rsN_busy = busy[rsN] & (rsN!=0), combinational.
REQ-033 Pipeline writes SHALL NOT alter busy bits.

Reset
REQ-034 While rst=1 at a rising edge: W_en=0, Rd=0, Wr_data=0, FIFO empty, all busy=0, sb_err=0; md_ready=0 during rst, stall_req=0 after.
REQ-035 Reset mid-operation SHALL drop buffered results without writing them.

Verification
REQ-036 pipe_wen=1, rd=5, data=0x1234 at N -> W_en=1, Rd=5, Wr_data=0x1234 at N+1; N+2 W_en=0.
REQ-037 md_issue rd=7; later md_valid rd=7 data=0xAA with pipe idle -> rs1=7 busy until pop, write at accept+1, rs1_busy=0 after.
REQ-038 pipe_wen every cycle, three md results rd=1,2,3 -> first two accepted, md_ready=0, stall_req=1; pipe stops -> writes rd=1 then rd=2 in order, then rd=3 accepted.
REQ-039 pipe_wen rd=0 with FIFO holding rd=4 -> FIFO entry written (Rd=4) next cycle.
REQ-040 md_issue rd=9 twice without completion -> sb_err=1, stays 1 until rst.
REQ-041 rst asserted with FIFO full -> next cycle W_en=0, count=0, busy all 0, no buffered write emerges.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file writeback arbiter between the pipeline and a buffered multi-cycle unit
module wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_wen,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  input  logic            md_valid,
  output logic            md_ready,
  input  logic [4:0]      md_rd,
  input  logic [XLEN-1:0] md_data,
  input  logic            md_issue,
  input  logic [4:0]      md_issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            stall_req,
  output logic            sb_err,
  output logic            W_en,
  output logic [4:0]      Rd,
  output logic [XLEN-1:0] Wr_data
);
  logic [4:0]      q_rd [2];
  logic [XLEN-1:0] q_data [2];
  logic [4:0]      n_rd [2];
  logic [XLEN-1:0] n_data [2];
  logic [1:0]      cnt;
  logic [31:0]     busy, set_m, clr_m;
  logic            pipe_req, push, pop, idx;
  assign md_ready  = (cnt != 2'd2) & ~rst;
  assign stall_req = cnt == 2'd2;
  assign pipe_req  = pipe_wen & |pipe_rd;
  assign push      = md_valid & md_ready & |md_rd;
  assign pop       = ~pipe_req & |cnt;
  assign idx       = cnt[0] & ~pop;
  assign set_m     = (md_issue & |md_issue_rd) ? 32'd1 << md_issue_rd : 32'd0;
  assign clr_m     = pop ? 32'd1 << q_rd[0] : 32'd0;
  assign rs1_busy  = busy[rs1] & |rs1;
  assign rs2_busy  = busy[rs2] & |rs2;
  // FIFO next state: shift head out on pop, then append behind whatever remains
  always_comb begin
    n_rd   = q_rd;
    n_data = q_data;
    if (pop) begin
      n_rd[0]   = q_rd[1];
      n_data[0] = q_data[1];
    end
    if (push) begin
      n_rd[idx]   = md_rd;
      n_data[idx] = md_data;
    end
  end
  // FIFO payload storage; validity is tracked by cnt so no reset is needed
  always_ff @(posedge clk) begin
    q_rd   <= n_rd;
    q_data <= n_data;
  end
  // Writeback register, occupancy, busy scoreboard and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      W_en    <= 1'b0;
      Rd      <= '0;
      Wr_data <= '0;
      cnt     <= '0;
      busy    <= '0;
      sb_err  <= 1'b0;
    end else begin
      W_en    <= pipe_req | pop;
      Rd      <= pipe_req ? pipe_rd : pop ? q_rd[0] : Rd;
      Wr_data <= pipe_req ? pipe_data : pop ? q_data[0] : Wr_data;
      cnt     <= cnt + {1'b0, push} - {1'b0, pop};
      busy    <= (busy & ~clr_m) | set_m;
      sb_err  <= sb_err | |(set_m & busy & ~clr_m);
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter writeback ordering, hazards and reset
module tb_wb_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        pipe_wen = 1'b0, md_valid = 1'b0, md_issue = 1'b0;
  logic [4:0]  pipe_rd = '0, md_rd = '0, md_issue_rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] pipe_data = '0, md_data = '0;
  logic        md_ready, rs1_busy, rs2_busy, stall_req, sb_err, W_en;
  logic [4:0]  Rd;
  logic [31:0] Wr_data;
  logic [36:0] exp_q [$];
  int          n_chk = 0, n_pass = 0;

  wb_arbiter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .stall_req(stall_req), .sb_err(sb_err),
    .W_en(W_en), .Rd(Rd), .Wr_data(Wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expw(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  task automatic pipe(input logic en, input logic [4:0] r, input logic [31:0] d);
    pipe_wen  = en;
    pipe_rd   = r;
    pipe_data = d;
  endtask

  task automatic md(input logic v, input logic [4:0] r, input logic [31:0] d);
    md_valid = v;
    md_rd    = r;
    md_data  = d;
  endtask

  always @(negedge clk) begin
    if (W_en) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got Rd=%0d data=%0h, required no write", Rd, Wr_data);
      end else begin
        chk("write", {27'd0, Rd, Wr_data}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    tick;
    tick;
    chk("rst_md_ready", md_ready, 0);
    chk("rst_W_en", W_en, 0);
    chk("rst_Rd", Rd, 0);
    chk("rst_Wr_data", Wr_data, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_sb_err", sb_err, 0);
    rst = 1'b0;
    #1;
    chk("md_ready_after_rst", md_ready, 1);
    pipe(1, 5'd5, 32'h1234); expw(5'd5, 32'h1234);
    tick;
    pipe(0, 0, 0);
    tick;
    chk("pipe_single_cycle", W_en, 0);
    md_issue = 1'b1; md_issue_rd = 5'd7;
    tick;
    md_issue = 1'b0; rs1 = 5'd7; rs2 = 5'd7;
    #1;
    chk("rs1_busy_set", rs1_busy, 1);
    chk("rs2_busy_set", rs2_busy, 1);
    md(1, 5'd7, 32'hAA);
    tick;
    md(0, 0, 0); expw(5'd7, 32'hAA);
    chk("rs1_busy_buffered", rs1_busy, 1);
    tick;
    chk("rs1_busy_cleared", rs1_busy, 0);
    chk("rs2_busy_cleared", rs2_busy, 0);
    tick;
    chk("md_write_single", W_en, 0);
    pipe(1, 5'd10, 32'hA0); md(1, 5'd1, 32'h11); expw(5'd10, 32'hA0);
    chk("fill_ready0", md_ready, 1);
    tick;
    pipe(1, 5'd11, 32'hA1); md(1, 5'd2, 32'h22); expw(5'd11, 32'hA1);
    tick;
    pipe(1, 5'd12, 32'hA2); md(1, 5'd3, 32'h33); expw(5'd12, 32'hA2);
    chk("full_md_ready", md_ready, 0);
    chk("full_stall", stall_req, 1);
    tick;
    pipe(0, 0, 0); expw(5'd1, 32'h11);
    chk("full_pop_ready", md_ready, 0);
    tick;
    expw(5'd2, 32'h22);
    chk("after_pop_ready", md_ready, 1);
    chk("after_pop_stall", stall_req, 0);
    tick;
    md(0, 0, 0); expw(5'd3, 32'h33);
    tick;
    tick;
    chk("fifo_drained", W_en, 0);
    pipe(1, 5'd15, 32'h15); md(1, 5'd4, 32'h44); expw(5'd15, 32'h15);
    tick;
    pipe(1, 5'd0, 32'hDEAD); md(0, 0, 0); expw(5'd4, 32'h44);
    tick;
    pipe(0, 0, 0);
    tick;
    chk("rd0_pipe_idle", W_en, 0);
    md(1, 5'd0, 32'hBAD);
    chk("rd0_md_ready", md_ready, 1);
    tick;
    md(0, 0, 0);
    tick;
    chk("rd0_md_discard", W_en, 0);
    chk("rd0_md_stall", stall_req, 0);
    md_issue = 1'b1; md_issue_rd = 5'd9;
    tick;
    chk("sb_err_first_issue", sb_err, 0);
    tick;
    md_issue = 1'b0; rs1 = 5'd9;
    chk("sb_err_set", sb_err, 1);
    #1;
    chk("rs1_busy_9", rs1_busy, 1);
    tick;
    tick;
    chk("sb_err_sticky", sb_err, 1);
    pipe(1, 5'd13, 32'h13); md(1, 5'd20, 32'h20); expw(5'd13, 32'h13);
    tick;
    pipe(1, 5'd14, 32'h14); md(1, 5'd21, 32'h21); expw(5'd14, 32'h14);
    tick;
    pipe(0, 0, 0); md(0, 0, 0);
    chk("pre_rst_full", stall_req, 1);
    rst = 1'b1;
    #1;
    chk("md_ready_in_rst", md_ready, 0);
    tick;
    chk("mid_rst_W_en", W_en, 0);
    chk("mid_rst_Rd", Rd, 0);
    chk("mid_rst_Wr_data", Wr_data, 0);
    chk("mid_rst_stall", stall_req, 0);
    chk("mid_rst_sb_err", sb_err, 0);
    rst = 1'b0;
    tick;
    chk("post_rst_W_en", W_en, 0);
    chk("post_rst_busy", rs1_busy, 0);
    chk("post_rst_ready", md_ready, 1);
    tick;
    tick;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
